// File: rtl/seg_fader_ctrl.sv
// Single-button controller for the segment fader: synchronise, debounce, classify short/long presses.
// Optional build macro CTRL_IDLE_TIMEOUT_EN returns the field selection to SPEED after inactivity.
module seg_fader_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 2000000,
    parameter int TIMEOUT_CYCLES  = 8000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic [2:0] speed,
    output logic [1:0] fade,
    output logic       direction,
    output logic [1:0] sel,
    output logic       changed
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    logic [1:0]        sync_r;
    logic              db_level_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic              db_accept_s;
    logic              db_rise_s;
    logic              db_fall_s;
    state_t            state_r;
    state_t            state_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              short_s;
    logic              long_s;
    logic              short_r;
    logic              timeout_s;
    logic [2:0]        speed_r;
    logic [1:0]        fade_r;
    logic              direction_r;
    logic [1:0]        sel_r;
    logic              changed_r;

    // Two-flop synchroniser: the only consumer of the raw button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn_in};
        end
    end

    // A level change is accepted on the last of the required consecutive mismatch cycles.
    always_comb begin
        db_accept_s = (sync_r[1] != db_level_r) && (db_cnt_r == DB_LAST);
        db_rise_s   = db_accept_s && sync_r[1];
        db_fall_s   = db_accept_s && !sync_r[1];
    end

    // Debounce counter and accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_level_r <= 1'b0;
            db_cnt_r   <= '0;
        end else if (sync_r[1] == db_level_r) begin
            db_cnt_r   <= '0;
        end else if (db_accept_s) begin
            db_level_r <= sync_r[1];
            db_cnt_r   <= '0;
        end else begin
            db_cnt_r   <= db_cnt_r + DB_ONE;
        end
    end

    // Press classifier next-state logic; release wins over a coincident long threshold.
    always_comb begin
        state_s = state_r;
        short_s = 1'b0;
        long_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (db_rise_s) begin
                    state_s = ST_HELD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (db_fall_s) begin
                    state_s = ST_IDLE;
                    short_s = 1'b1;
                end else if (hold_cnt_r >= HOLD_LONG) begin
                    state_s = ST_LONG;
                    long_s  = 1'b1;
                end else begin
                    state_s = ST_HELD;
                end
            end
            ST_LONG: begin
                if (db_fall_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LONG;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Hold counter sits at zero outside HELD, so it is already clear on entry; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_r <= '0;
        end else if (state_r != ST_HELD) begin
            hold_cnt_r <= '0;
        end else if (hold_cnt_r != HOLD_MAX) begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

`ifdef CTRL_IDLE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    logic [IDLE_W-1:0] idle_cnt_r;

    // Idle counter: cleared by any accepted edge, parks at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (db_accept_s) begin
            idle_cnt_r <= '0;
        end else if (idle_cnt_r != IDLE_LIMIT) begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    assign timeout_s = (idle_cnt_r == IDLE_LIMIT) && (state_r == ST_IDLE) && (sel_r != 2'd0);
`else
    assign timeout_s = 1'b0;
`endif

    // Field registers: short action lands one cycle after release, sel moves on the long threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_r     <= 3'd0;
            fade_r      <= 2'd3;
            direction_r <= 1'b1;
            sel_r       <= 2'd0;
            changed_r   <= 1'b0;
            short_r     <= 1'b0;
        end else begin
            short_r   <= short_s;
            changed_r <= 1'b0;
            if (short_r) begin
                changed_r <= 1'b1;
                case (sel_r)
                    2'd0:    speed_r     <= speed_r + 3'd1;
                    2'd1:    fade_r      <= fade_r + 2'd1;
                    2'd2:    direction_r <= ~direction_r;
                    default: speed_r     <= speed_r;
                endcase
            end
            if (long_s) begin
                sel_r     <= (sel_r == 2'd2) ? 2'd0 : (sel_r + 2'd1);
                changed_r <= 1'b1;
            end else if (timeout_s) begin
                sel_r     <= 2'd0;
                changed_r <= 1'b1;
            end
        end
    end

    assign speed     = speed_r;
    assign fade      = fade_r;
    assign direction = direction_r;
    assign sel       = sel_r;
    assign changed   = changed_r;

endmodule

// File: tb/tb_seg_fader_ctrl.sv
// Scoreboard bench for seg_fader_ctrl: expected output snapshots are queued when presses are
// driven and popped whenever the controller pulses changed.
module tb_seg_fader_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic [2:0] speed;
    logic [1:0] fade;
    logic       direction;
    logic [1:0] sel;
    logic       changed;

    int         checks_r;
    int         errors_r;
    logic [7:0] exp_q[$];
    logic [2:0] m_speed;
    logic [1:0] m_fade;
    logic       m_dir;
    logic [1:0] m_sel;
    logic       mon_en;
    logic       rst_q;
    logic [7:0] obs_s;
    logic [7:0] prev_s;
    logic [7:0] exp_s;

    seg_fader_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .speed    (speed),
        .fade     (fade),
        .direction(direction),
        .sel      (sel),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_word();
        return {m_speed, m_fade, m_dir, m_sel};
    endfunction

    task automatic model_reset();
        m_speed = 3'd0;
        m_fade  = 2'd3;
        m_dir   = 1'b1;
        m_sel   = 2'd0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int hi, input int lo);
        btn_in = 1'b1;
        cycles(hi);
        btn_in = 1'b0;
        cycles(lo);
    endtask

    task automatic short_press();
        case (m_sel)
            2'd0:    m_speed = m_speed + 3'd1;
            2'd1:    m_fade  = m_fade + 2'd1;
            2'd2:    m_dir   = ~m_dir;
            default: m_speed = m_speed;
        endcase
        exp_q.push_back(model_word());
        press(10, 10);
    endtask

    task automatic long_press();
        m_sel = (m_sel == 2'd2) ? 2'd0 : (m_sel + 2'd1);
        exp_q.push_back(model_word());
        press(40, 10);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_reset();
        cycles(n);
        reset = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_outputs"}, 32'({speed, fade, direction, sel}), 32'(model_word()));
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Reset as sampled by the DUT on the most recent rising edge.
    always @(posedge clk) rst_q <= reset;

    // Monitor: every output movement must coincide with a single changed pulse matching the queue head.
    always @(negedge clk) begin
        obs_s = {speed, fade, direction, sel};
        if (mon_en && !rst_q) begin
            if (changed || (obs_s != prev_s)) begin
                check("chg_pulse", 32'(changed), 32'(obs_s != prev_s));
            end
            if (changed) begin
                if (exp_q.size() == 0) begin
                    check("chg_unexpected", 32'(changed), 32'd0);
                end else begin
                    exp_s = exp_q.pop_front();
                    check("chg_value", 32'(obs_s), 32'(exp_s));
                end
            end
        end
        prev_s = obs_s;
    end

    initial begin
        checks_r = 0;
        errors_r = 0;
        mon_en   = 1'b0;
        btn_in   = 1'b0;
        prev_s   = 8'd0;
        do_reset(3);
        mon_en = 1'b1;

        // Idle after reset: reset values, no pulses.
        cycles(20);
        check("rst_changed", 32'(changed), 32'd0);
        check("rst_outputs", 32'({speed, fade, direction, sel}), 32'({3'd0, 2'd3, 1'b1, 2'd0}));
        check_state("idle");

        // Eight short presses step speed 1..7 then wrap to 0.
        for (int i = 0; i < 8; i++) begin
            short_press();
        end
        check_state("speed_steps");
        check("speed_wrap", 32'(speed), 32'd0);

        // Short glitches never pass the debouncer.
        for (int i = 0; i < 20; i++) begin
            press(3, 5);
        end
        cycles(10);
        check_state("glitch");

        // Long press selects FADE; release is silent; short press wraps fade 3 -> 0.
        long_press();
        check_state("long_sel");
        check("long_sel_value", 32'(sel), 32'd1);
        short_press();
        check_state("fade_wrap");
        check("fade_value", 32'(fade), 32'd0);

        // Two long presses reach DIR, short press flips direction.
        do_reset(2);
        cycles(5);
        long_press();
        long_press();
        check("dir_sel_value", 32'(sel), 32'd2);
        short_press();
        check("dir_value", 32'(direction), 32'd0);
`ifdef CTRL_IDLE_TIMEOUT_EN
        m_sel = 2'd0;
        exp_q.push_back(model_word());
`endif
        cycles(80);
        check_state("idle_timeout");

        // Reset mid-press: press is abandoned; the still-held button becomes a fresh short press.
        btn_in = 1'b1;
        cycles(14);
        reset = 1'b1;
        model_reset();
        cycles(2);
        check("midrst_outputs", 32'({speed, fade, direction, sel}), 32'({3'd0, 2'd3, 1'b1, 2'd0}));
        check("midrst_changed", 32'(changed), 32'd0);
        reset = 1'b0;
        cycles(10);
        m_speed = m_speed + 3'd1;
        exp_q.push_back(model_word());
        btn_in = 1'b0;
        cycles(20);
        check_state("midrst_release");

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
